// File: rtl/vend_controller_if.sv
// Coin, vend and dispenser signals shared between the vending controller
// and its environment.
interface vend_controller_if;
  logic [1:0] d;
  logic       sel;
  logic       cancel;
  logic       disp_ack;
  logic       disp_req;
  logic       chg_out;
  logic       coin_rej;
  logic [5:0] credit;
  logic       busy;

  modport master (
    output d, sel, cancel, disp_ack,
    input  disp_req, chg_out, coin_rej, credit, busy
  );

  modport slave (
    input  d, sel, cancel, disp_ack,
    output disp_req, chg_out, coin_rej, credit, busy
  );
endinterface

// File: rtl/vend_controller.sv
// Vending controller: accepts coins into a bounded credit, vends on request,
// pays change as 5-unit pulses, and refunds automatically after an idle period.
//
// state    | meaning
// IDLE     | no credit, waiting for the first coin
// CREDIT   | credit held, waiting for sel / cancel / more coins / timeout
// VEND     | disp_req high until the dispenser acknowledges
// CHANGE   | one chg_out pulse per cycle until credit reaches 0
module vend_controller #(
  parameter int PRICE      = 15,
  parameter int MAX_CREDIT = 35,
  parameter int TIMEOUT    = 200
) (
  input  logic             clk_i,
  input  logic             rst_i,
  vend_controller_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CREDIT = 2'd1;
  localparam logic [1:0] S_VEND   = 2'd2;
  localparam logic [1:0] S_CHANGE = 2'd3;

  localparam int          TW       = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);
  localparam logic [6:0]  MAX_C    = 7'(MAX_CREDIT);
  localparam logic [5:0]  PRICE_C  = 6'(PRICE);
  localparam logic [5:0]  CHG_UNIT = 6'd5;

  logic [1:0]    state_q, state_d;
  logic [5:0]    credit_q, credit_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          disp_req_q, disp_req_d;
  logic          chg_q, chg_d;
  logic          rej_q, rej_d;
  logic          busy_q, busy_d;

  logic [5:0] coin_val;
  logic       coin_vld;
  logic [6:0] credit_sum;
  logic       coin_fits;

  always_comb begin
    coin_val = 6'd0;
    case (bus.d)
      2'b01:   coin_val = 6'd5;
      2'b10:   coin_val = 6'd10;
      2'b11:   coin_val = 6'd20;
      default: coin_val = 6'd0;
    endcase
  end

  assign coin_vld   = |bus.d;
  assign credit_sum = {1'b0, credit_q} + {1'b0, coin_val};
  assign coin_fits  = (credit_sum <= MAX_C);

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    tmr_d    = tmr_q;
    chg_d    = 1'b0;
    rej_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (coin_vld) begin
          credit_d = coin_val;
          tmr_d    = TMR_LOAD;
          state_d  = S_CREDIT;
        end
      end

      S_CREDIT: begin
        if (bus.cancel) begin
          rej_d   = coin_vld;
          state_d = S_CHANGE;
        end else if (bus.sel && (credit_q >= PRICE_C)) begin
          credit_d = credit_q - PRICE_C;
          rej_d    = coin_vld;
          state_d  = S_VEND;
        end else if (coin_vld && coin_fits) begin
          credit_d = credit_sum[5:0];
          tmr_d    = TMR_LOAD;
        end else begin
          // Rejected coins and ignored sel still count as idle time.
          rej_d = coin_vld;
          if (tmr_q == '0) begin
            state_d = S_CHANGE;
          end else begin
            tmr_d = tmr_q - TMR_ONE;
          end
        end
      end

      S_VEND: begin
        rej_d = coin_vld;
        if (bus.disp_ack) begin
          state_d = (credit_q != 6'd0) ? S_CHANGE : S_IDLE;
        end
      end

      S_CHANGE: begin
        rej_d = coin_vld;
        if (credit_q != 6'd0) begin
          credit_d = credit_q - CHG_UNIT;
          chg_d    = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    disp_req_d = (state_d == S_VEND);
    busy_d     = (state_d == S_VEND) || (state_d == S_CHANGE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      credit_q   <= 6'd0;
      tmr_q      <= '0;
      disp_req_q <= 1'b0;
      chg_q      <= 1'b0;
      rej_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      tmr_q      <= tmr_d;
      disp_req_q <= disp_req_d;
      chg_q      <= chg_d;
      rej_q      <= rej_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.credit   = credit_q;
  assign bus.disp_req = disp_req_q;
  assign bus.chg_out  = chg_q;
  assign bus.coin_rej = rej_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: directed scenarios followed by random traffic,
// every cycle compared against a behavioural credit/mode model.
module tb_vend_controller;

  localparam int PRICE      = 15;
  localparam int MAX_CREDIT = 35;
  localparam int TIMEOUT    = 200;

  localparam int M_IDLE = 0, M_HOLD = 1, M_DISPENSE = 2, M_REFUND = 3;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;

  vend_controller_if bus ();

  vend_controller #(.PRICE(PRICE), .MAX_CREDIT(MAX_CREDIT), .TIMEOUT(TIMEOUT)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int chg_seen = 0;
  int rej_seen = 0;

  int m_mode   = M_IDLE;
  int m_credit = 0;
  int m_idle   = 0;
  bit e_chg, e_rej;

  function automatic int coin_units(input logic [1:0] code);
    int tbl[4] = '{0, 5, 10, 20};
    return tbl[code];
  endfunction

  function void model_step(input int v, input bit s, input bit c, input bit a, input bit r);
    e_chg = 1'b0;
    e_rej = 1'b0;
    if (r) begin
      m_mode = M_IDLE; m_credit = 0; m_idle = 0;
    end else if (m_mode == M_IDLE) begin
      if (v > 0) begin m_credit = v; m_mode = M_HOLD; m_idle = 0; end
    end else if (m_mode == M_HOLD) begin
      if (c) begin
        e_rej = (v > 0); m_mode = M_REFUND;
      end else if (s && m_credit >= PRICE) begin
        m_credit -= PRICE; e_rej = (v > 0); m_mode = M_DISPENSE;
      end else if (v > 0 && m_credit + v <= MAX_CREDIT) begin
        m_credit += v; m_idle = 0;
      end else begin
        e_rej = (v > 0);
        m_idle++;
        if (m_idle >= TIMEOUT) m_mode = M_REFUND;
      end
    end else if (m_mode == M_DISPENSE) begin
      e_rej = (v > 0);
      if (a) m_mode = (m_credit > 0) ? M_REFUND : M_IDLE;
    end else begin
      e_rej = (v > 0);
      if (m_credit > 0) begin m_credit -= 5; e_chg = 1'b1; end
      else m_mode = M_IDLE;
    end
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input logic [1:0] dd, input bit s, input bit c, input bit a, input bit r);
    bus.d = dd; bus.sel = s; bus.cancel = c; bus.disp_ack = a; rst_i = r;
    @(posedge clk_i);
    cyc++;
    model_step(coin_units(dd), s, c, a, r);
    #1;
    chk("credit",   int'(bus.credit),   m_credit);
    chk("disp_req", int'(bus.disp_req), int'(m_mode == M_DISPENSE));
    chk("busy",     int'(bus.busy),     int'(m_mode == M_DISPENSE || m_mode == M_REFUND));
    chk("chg_out",  int'(bus.chg_out),  int'(e_chg));
    chk("coin_rej", int'(bus.coin_rej), int'(e_rej));
    chg_seen += int'(bus.chg_out);
    rej_seen += int'(bus.coin_rej);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 0, 0, 0, 0);
  endtask

  initial begin
    bus.d = 2'b00; bus.sel = 0; bus.cancel = 0; bus.disp_ack = 0;

    // Reset, with active inputs that must be overridden
    step(2'b11, 1, 1, 1, 1);
    step(2'b00, 0, 0, 0, 1);
    chk("reset_credit", int'(bus.credit), 0);

    // Exact vend: 10 + 5, sel, ack three cycles after entry
    chg_seen = 0;
    step(2'b10, 0, 0, 0, 0); chk("exact_c10", int'(bus.credit), 10);
    step(2'b01, 0, 0, 0, 0); chk("exact_c15", int'(bus.credit), 15);
    step(2'b00, 1, 0, 1, 0); chk("exact_c0", int'(bus.credit), 0);
    chk("exact_req1", int'(bus.disp_req), 1);
    step(2'b00, 0, 0, 0, 0);
    step(2'b00, 0, 0, 0, 0); chk("exact_req3", int'(bus.disp_req), 1);
    step(2'b00, 0, 0, 1, 0); chk("exact_req_off", int'(bus.disp_req), 0);
    chk("exact_idle", int'(bus.busy), 0);
    chk("exact_no_chg", chg_seen, 0);

    // Vend with change: 20 + 10, sel, ack, three change pulses
    chg_seen = 0;
    step(2'b11, 0, 0, 0, 0);
    step(2'b10, 0, 0, 0, 0); chk("chg_c30", int'(bus.credit), 30);
    step(2'b00, 1, 0, 0, 0); chk("chg_c15", int'(bus.credit), 15);
    step(2'b00, 0, 0, 1, 0); chk("chg_busy", int'(bus.busy), 1);
    idle_cycles(3);          chk("chg_pulses", chg_seen, 3);
    step(2'b00, 0, 0, 0, 0); chk("chg_done", int'(bus.busy), 0);
    chk("chg_credit0", int'(bus.credit), 0);

    // Overflow: 20, 10, then 10 rejected at 30; then refund it
    rej_seen = 0;
    step(2'b11, 0, 0, 0, 0);
    step(2'b10, 0, 0, 0, 0);
    step(2'b10, 0, 0, 0, 0); chk("ovf_rej", int'(bus.coin_rej), 1);
    chk("ovf_credit", int'(bus.credit), 30);
    step(2'b01, 0, 0, 0, 0); chk("ovf_edge35", int'(bus.credit), 35);
    step(2'b00, 0, 1, 0, 0);
    idle_cycles(8);          chk("ovf_refund_idle", int'(bus.busy), 0);

    // Insufficient sel, then cancel together with a coin
    chg_seen = 0;
    step(2'b10, 0, 0, 0, 0);
    step(2'b00, 1, 0, 0, 0); chk("insuf_hold", int'(bus.credit), 10);
    chk("insuf_notbusy", int'(bus.busy), 0);
    step(2'b01, 0, 1, 0, 0); chk("cancel_rej", int'(bus.coin_rej), 1);
    chk("cancel_credit", int'(bus.credit), 10);
    idle_cycles(3);          chk("cancel_pulses", chg_seen, 2);
    chk("cancel_idle", int'(bus.busy), 0);

    // Timeout after a single coin
    chg_seen = 0;
    step(2'b01, 0, 0, 0, 0);
    idle_cycles(TIMEOUT - 1); chk("tmo_not_yet", int'(bus.busy), 0);
    step(2'b00, 0, 0, 0, 0);  chk("tmo_change", int'(bus.busy), 1);
    idle_cycles(2);           chk("tmo_pulses", chg_seen, 1);
    chk("tmo_idle", int'(bus.busy), 0);

    // Reset during VEND with credit 15
    chg_seen = 0;
    step(2'b11, 0, 0, 0, 0);
    step(2'b10, 0, 0, 0, 0);
    step(2'b00, 1, 0, 0, 0); chk("rstv_credit15", int'(bus.credit), 15);
    step(2'b00, 0, 0, 0, 1); chk("rstv_credit0", int'(bus.credit), 0);
    chk("rstv_req", int'(bus.disp_req), 0);
    idle_cycles(3);          chk("rstv_no_chg", chg_seen, 0);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      logic [1:0] dd;
      dd = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      step(dd,
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 149) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
